// File: rtl/de2i150_io_pkg.sv
// Shared types and constants for the DE2i-150 switch/key/LED controller.
package de2i150_io_pkg;

  localparam int unsigned N_SW  = 18;
  localparam int unsigned N_KEY = 4;

  localparam logic [N_SW-1:0] CHASE_SEED = 18'h00001;

  typedef enum logic [1:0] {
    MIRROR = 2'd0,
    COUNT  = 2'd1,
    CHASE  = 2'd2,
    HOLD   = 2'd3
  } mode_e;

  // Green LED status word, MSB first.
  typedef struct packed {
    logic             paused;
    logic [3:0]       mode_onehot;
    logic [N_KEY-1:0] pressed;
  } ledg_t;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MIRROR:  return COUNT;
      COUNT:   return CHASE;
      CHASE:   return HOLD;
      default: return MIRROR;
    endcase
  endfunction

  function automatic logic [3:0] mode_onehot(input mode_e m);
    case (m)
      MIRROR:  return 4'b0001;
      COUNT:   return 4'b0010;
      CHASE:   return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and press pulse.
// key_n is active-low; pressed/press are active-high.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          meta_n;
  logic          sync_n;
  logic [CW-1:0] cnt;

  // Counter only runs while the synced level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_n  <= 1'b1;
      sync_n  <= 1'b1;
      cnt     <= '0;
      pressed <= 1'b0;
      press   <= 1'b0;
    end else begin
      meta_n <= key_n;
      sync_n <= meta_n;
      press  <= 1'b0;
      if (sync_n == ~pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt     <= '0;
        pressed <= ~sync_n;
        press   <= ~sync_n;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/de2i150_led_sequencer.sv
// DE2i-150 board I/O controller: debounced keys drive a mode FSM that selects
// the LEDR source (switch mirror, counter, walking-one chase, frozen snapshot).
module de2i150_led_sequencer
  import de2i150_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned TICK_CYCLES     = 12_500_000
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic [N_SW-1:0]  SW,
  input  logic [N_KEY-1:0] KEY,
  output logic [N_SW-1:0]  LEDR,
  output logic [8:0]       LEDG
);

  localparam int unsigned PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [N_KEY-1:0] pressed;
  logic [N_KEY-1:0] press;

  logic [N_SW-1:0] sw_meta;
  logic [N_SW-1:0] sw_sync;

  mode_e           mode,     mode_n;
  logic [N_SW-1:0] count,    count_n;
  logic [N_SW-1:0] chase,    chase_n;
  logic [N_SW-1:0] snapshot, snapshot_n;
  logic            paused,   paused_n;
  logic [PW-1:0]   presc,    presc_n;
  logic [N_SW-1:0] ledr_n;
  ledg_t           ledg_n;
  logic            tick_c;

  for (genvar i = 0; i < int'(N_KEY); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk     (CLOCK_50),
      .rst     (RST),
      .key_n   (KEY[i]),
      .pressed (pressed[i]),
      .press   (press[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      mode     <= MIRROR;
      count    <= '0;
      chase    <= CHASE_SEED;
      snapshot <= '0;
      paused   <= 1'b0;
      presc    <= '0;
      LEDR     <= '0;
      LEDG     <= '0;
    end else begin
      mode     <= mode_n;
      count    <= count_n;
      chase    <= chase_n;
      snapshot <= snapshot_n;
      paused   <= paused_n;
      presc    <= presc_n;
      LEDR     <= ledr_n;
      LEDG     <= ledg_n;
    end
  end

  // Exclusive priority: soft clear, count load, mode advance, then tick step.
  always_comb begin
    mode_n     = mode;
    count_n    = count;
    chase_n    = chase;
    snapshot_n = snapshot;
    paused_n   = paused;
    tick_c     = (presc == PW'(TICK_CYCLES - 1));
    presc_n    = tick_c ? '0 : presc + PW'(1);

    if (press[3]) begin
      count_n  = '0;
      chase_n  = CHASE_SEED;
      paused_n = 1'b0;
      presc_n  = '0;
    end else if (press[2]) begin
      count_n = sw_sync;
      if (press[1]) paused_n = ~paused;
    end else if (press[0]) begin
      mode_n   = next_mode(mode);
      paused_n = 1'b0;
      presc_n  = '0;
      if (mode_n == CHASE) chase_n = CHASE_SEED;
      if (mode_n == HOLD) snapshot_n = LEDR;
    end else begin
      if (press[1]) paused_n = ~paused;
      if (tick_c && !paused) begin
        case (mode)
          COUNT:   count_n = count + N_SW'(1);
          CHASE:   chase_n = {chase[N_SW-2:0], chase[N_SW-1]};
          default: ;
        endcase
      end
    end
  end

  // LED sources follow the next-state values so effects land one cycle after a press.
  always_comb begin
    ledr_n = sw_sync;
    case (mode_n)
      MIRROR:  ledr_n = sw_sync;
      COUNT:   ledr_n = count_n;
      CHASE:   ledr_n = chase_n;
      default: ledr_n = snapshot_n;
    endcase
    ledg_n.paused      = paused_n;
    ledg_n.mode_onehot = mode_onehot(mode_n);
    ledg_n.pressed     = pressed;
  end

endmodule

// File: tb/tb_de2i150_led_sequencer.sv
// Directed bench for de2i150_led_sequencer with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
module tb_de2i150_led_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic [3:0]  key;
  logic [17:0] ledr;
  logic [8:0]  ledg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  de2i150_led_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .TICK_CYCLES     (8)
  ) dut (
    .CLOCK_50 (clk),
    .RST      (rst),
    .SW       (sw),
    .KEY      (key),
    .LEDR     (ledr),
    .LEDG     (ledg)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; sw = 18'h2A5A5; key = 4'hF;
    cyc(1);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL reset_ledr_a: LEDR=%h expected 00000", ledr); end
    checks++; if (ledg !== 9'h0)  begin errors++; $display("FAIL reset_ledg_a: LEDG=%h expected 000", ledg); end
    cyc(2);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL reset_ledr_b: LEDR=%h expected 00000", ledr); end
    checks++; if (ledg !== 9'h0)  begin errors++; $display("FAIL reset_ledg_b: LEDG=%h expected 000", ledg); end
    rst = 1'b0;
    cyc(1);
    checks++; if (ledg !== 9'h010) begin errors++; $display("FAIL reset_ledg_mirror: LEDG=%h expected 010", ledg); end
    cyc(1);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL mirror_sync_lag: LEDR=%h expected 00000", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h2A5A5) begin errors++; $display("FAIL mirror_value: LEDR=%h expected 2a5a5", ledr); end
  endtask

  task automatic test_debounce_count;
    key[0] = 1'b0; cyc(1);
    key[0] = 1'b1; cyc(1);
    key[0] = 1'b0;
    cyc(6);
    checks++; if (ledg[7:4] !== 4'b0001) begin errors++; $display("FAIL debounce_early: mode=%b expected 0001", ledg[7:4]); end
    cyc(1);
    checks++; if (ledg !== 9'h021) begin errors++; $display("FAIL count_entry_ledg: LEDG=%h expected 021", ledg); end
    checks++; if (ledr !== 18'h0)  begin errors++; $display("FAIL count_entry_ledr: LEDR=%h expected 00000", ledr); end
    cyc(7);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL count_pre_tick: LEDR=%h expected 00000", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h1) begin errors++; $display("FAIL count_tick1: LEDR=%h expected 00001", ledr); end
    cyc(8);
    checks++; if (ledr !== 18'h2) begin errors++; $display("FAIL count_tick2: LEDR=%h expected 00002", ledr); end
    key[0] = 1'b1; sw = 18'h3FFFE; key[2] = 1'b0;
  endtask

  task automatic test_count_load;
    cyc(6);
    checks++; if (ledr !== 18'h2) begin errors++; $display("FAIL load_before: LEDR=%h expected 00002", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h3FFFE) begin errors++; $display("FAIL load_value: LEDR=%h expected 3fffe", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h3FFFF) begin errors++; $display("FAIL load_tick: LEDR=%h expected 3ffff", ledr); end
    cyc(7);
    checks++; if (ledr !== 18'h3FFFF) begin errors++; $display("FAIL load_hold: LEDR=%h expected 3ffff", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL count_wrap: LEDR=%h expected 00000", ledr); end
    key[2] = 1'b1; key[0] = 1'b0;
  endtask

  task automatic test_chase_pause;
    cyc(6);
    checks++; if (ledg[7:4] !== 4'b0010) begin errors++; $display("FAIL chase_early: mode=%b expected 0010", ledg[7:4]); end
    cyc(1);
    checks++; if (ledr !== 18'h1)   begin errors++; $display("FAIL chase_entry_ledr: LEDR=%h expected 00001", ledr); end
    checks++; if (ledg !== 9'h041) begin errors++; $display("FAIL chase_entry_ledg: LEDG=%h expected 041", ledg); end
    key[0] = 1'b1;
    cyc(135);
    checks++; if (ledr !== 18'h10000) begin errors++; $display("FAIL chase_16: LEDR=%h expected 10000", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h20000) begin errors++; $display("FAIL chase_17: LEDR=%h expected 20000", ledr); end
    cyc(8);
    checks++; if (ledr !== 18'h1) begin errors++; $display("FAIL chase_wrap: LEDR=%h expected 00001", ledr); end
    key[1] = 1'b0;
    cyc(7);
    checks++; if (ledg[8] !== 1'b1) begin errors++; $display("FAIL pause_set: paused=%b expected 1", ledg[8]); end
    key[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      checks++; if (ledr !== 18'h1) begin errors++; $display("FAIL pause_static[%0d]: LEDR=%h expected 00001", i, ledr); end
    end
    key[1] = 1'b0;
    cyc(7);
    checks++; if (ledg[8] !== 1'b0) begin errors++; $display("FAIL pause_clear: paused=%b expected 0", ledg[8]); end
    cyc(1);
    checks++; if (ledr !== 18'h1) begin errors++; $display("FAIL resume_pre_tick: LEDR=%h expected 00001", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h2) begin errors++; $display("FAIL resume_tick: LEDR=%h expected 00002", ledr); end
    key[1] = 1'b1; key[0] = 1'b0;
  endtask

  task automatic test_hold;
    cyc(7);
    checks++; if (ledr !== 18'h2)   begin errors++; $display("FAIL hold_entry_ledr: LEDR=%h expected 00002", ledr); end
    checks++; if (ledg !== 9'h081) begin errors++; $display("FAIL hold_entry_ledg: LEDG=%h expected 081", ledg); end
    key[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sw = 18'(i * 4099 + 7);
      cyc(1);
      checks++; if (ledr !== 18'h2) begin errors++; $display("FAIL hold_frozen[%0d]: LEDR=%h expected 00002", i, ledr); end
    end
    sw = 18'h15A5A;
    cyc(4);
    key[0] = 1'b0;
    cyc(6);
    checks++; if (ledr !== 18'h2) begin errors++; $display("FAIL hold_before_exit: LEDR=%h expected 00002", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h15A5A) begin errors++; $display("FAIL mirror_return_ledr: LEDR=%h expected 15a5a", ledr); end
    checks++; if (ledg !== 9'h011)    begin errors++; $display("FAIL mirror_return_ledg: LEDG=%h expected 011", ledg); end
  endtask

  task automatic test_clear_and_reset;
    key[0] = 1'b1; sw = 18'h12345;
    cyc(8);
    key[0] = 1'b0;
    cyc(7);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL count_retained: LEDR=%h expected 00000", ledr); end
    key[0] = 1'b1;
    cyc(2);
    key[2] = 1'b0;
    cyc(7);
    checks++; if (ledr !== 18'h12345) begin errors++; $display("FAIL load_sw: LEDR=%h expected 12345", ledr); end
    key[2] = 1'b1;
    cyc(7);
    checks++; if (ledr !== 18'h12346) begin errors++; $display("FAIL load_sw_tick: LEDR=%h expected 12346", ledr); end
    cyc(1);
    key = 4'b0011;
    cyc(6);
    checks++; if (ledr !== 18'h12346) begin errors++; $display("FAIL clear_before: LEDR=%h expected 12346", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h0)        begin errors++; $display("FAIL clear_wins: LEDR=%h expected 00000", ledr); end
    checks++; if (ledg[8:4] !== 5'b00010) begin errors++; $display("FAIL clear_mode: LEDG[8:4]=%b expected 00010", ledg[8:4]); end
    cyc(7);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL clear_presc: LEDR=%h expected 00000", ledr); end
    cyc(1);
    checks++; if (ledr !== 18'h1) begin errors++; $display("FAIL clear_tick: LEDR=%h expected 00001", ledr); end
    key = 4'hF;
    cyc(8);
    key[0] = 1'b0;
    cyc(3);
    rst = 1'b1;
    cyc(1);
    checks++; if (ledr !== 18'h0) begin errors++; $display("FAIL midrst_ledr: LEDR=%h expected 00000", ledr); end
    checks++; if (ledg !== 9'h0)  begin errors++; $display("FAIL midrst_ledg: LEDG=%h expected 000", ledg); end
    key[0] = 1'b1;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc(1);
      checks++; if (ledg[7:4] !== 4'b0001) begin errors++; $display("FAIL midrst_no_press[%0d]: mode=%b expected 0001", i, ledg[7:4]); end
    end
    key[0] = 1'b0;
    cyc(6);
    checks++; if (ledg[7:4] !== 4'b0001) begin errors++; $display("FAIL repress_early: mode=%b expected 0001", ledg[7:4]); end
    cyc(1);
    checks++; if (ledg[7:4] !== 4'b0010) begin errors++; $display("FAIL repress_mode: mode=%b expected 0010", ledg[7:4]); end
    checks++; if (ledr !== 18'h0)        begin errors++; $display("FAIL repress_count: LEDR=%h expected 00000", ledr); end
    key[0] = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    sw  = '0;
    key = 4'hF;
    test_reset();
    test_debounce_count();
    test_count_load();
    test_chase_pause();
    test_hold();
    test_clear_and_reset();
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
